// File: rtl/fpga_output_display.sv
// Output display block: captures a 16-bit value on a FLAG_output rising edge,
// converts it to five BCD digits with a sequential double-dabble engine and
// drives five active-low seven-segment displays with optional leading-zero
// blanking. FPGA_output_done pulses for one cycle when the displays update.
module fpga_output_display #(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FLAG_output,
   input  logic [15:0] output_data,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic        FPGA_output_busy,
   output logic        FPGA_output_done
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DIGITS = 5;
   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned ITER   = DATA_W;
   localparam int unsigned SEG_W  = 7;

   localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h40;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_UPPER_RST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      UPDATE
   } state_t;

   state_t             state;
   logic               flag_prev;
   logic               request;
   logic [DATA_W-1:0]  bin;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   bcd_adj;
   logic [CNT_W-1:0]   cnt;
   logic [SEG_W-1:0]   seg_next [DIGITS];

   // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   assign request = FLAG_output & ~flag_prev;

   // Rising-edge detector for the output request level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flag_prev <= 1'b0;
      else       flag_prev <= FLAG_output;
   end

   // Double-dabble add-3 step: each nibble >= 5 gets +3, no inter-nibble carry
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Segment patterns for the finished BCD value, blanking leading zeros above HEX0
   always_comb begin
      logic lead;
      lead = 1'b1;
      seg_next = '{default: SEG_BLANK};
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         lead = lead && (bcd[4*k +: 4] == 4'd0);
         if (BLANK_LEADING && lead && (k != 0)) seg_next[k] = SEG_BLANK;
         else                                   seg_next[k] = seg_decode(bcd[4*k +: 4]);
      end
   end

   // Conversion FSM with registered displays and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         bin              <= '0;
         bcd              <= '0;
         cnt              <= '0;
         HEX0             <= SEG_ZERO;
         HEX1             <= SEG_UPPER_RST;
         HEX2             <= SEG_UPPER_RST;
         HEX3             <= SEG_UPPER_RST;
         HEX4             <= SEG_UPPER_RST;
         FPGA_output_busy <= 1'b0;
         FPGA_output_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               FPGA_output_done <= 1'b0;
               if (request) begin
                  bin              <= output_data;
                  bcd              <= '0;
                  cnt              <= '0;
                  FPGA_output_busy <= 1'b1;
                  state            <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(ITER - 1)) state <= UPDATE;
            end
            UPDATE: begin
               HEX0             <= seg_next[0];
               HEX1             <= seg_next[1];
               HEX2             <= seg_next[2];
               HEX3             <= seg_next[3];
               HEX4             <= seg_next[4];
               FPGA_output_done <= 1'b1;
               FPGA_output_busy <= 1'b0;
               state            <= IDLE;
            end
            default: begin
               FPGA_output_busy <= 1'b0;
               FPGA_output_done <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_output_display.sv
// Bench for fpga_output_display: a blanking instance and a non-blanking
// instance share the same stimulus; a countdown model predicts every output.
module tb_fpga_output_display;

   logic        clk = 1'b0;
   logic        reset;
   logic        flag;
   logic [15:0] data;

   logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3, b_hex4;
   logic [6:0]  n_hex0, n_hex1, n_hex2, n_hex3, n_hex4;
   logic        b_busy, b_done, n_busy, n_done;

   logic [34:0] b_all, n_all;
   assign b_all = {b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};
   assign n_all = {n_hex4, n_hex3, n_hex2, n_hex1, n_hex0};

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   fpga_output_display #(.BLANK_LEADING(1'b1)) u_blank (
      .clk(clk), .reset(reset), .FLAG_output(flag), .output_data(data),
      .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2), .HEX3(b_hex3), .HEX4(b_hex4),
      .FPGA_output_busy(b_busy), .FPGA_output_done(b_done)
   );

   fpga_output_display #(.BLANK_LEADING(1'b0)) u_noblank (
      .clk(clk), .reset(reset), .FLAG_output(flag), .output_data(data),
      .HEX0(n_hex0), .HEX1(n_hex1), .HEX2(n_hex2), .HEX3(n_hex3), .HEX4(n_hex4),
      .FPGA_output_busy(n_busy), .FPGA_output_done(n_done)
   );

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'h40; 1: s = 7'h79; 2: s = 7'h24; 3: s = 7'h30; 4: s = 7'h19;
         5: s = 7'h12; 6: s = 7'h02; 7: s = 7'h78; 8: s = 7'h00; 9: s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Expected {HEX4..HEX0} for a decimal value, computed with plain division
   function automatic logic [34:0] expect_disp(input int v, input bit blank);
      logic [34:0] r;
      int digit [5];
      int rest;
      int highest;
      rest = v;
      highest = 0;
      for (int k = 0; k < 5; k++) begin
         digit[k] = rest % 10;
         rest = rest / 10;
         if (digit[k] != 0) highest = k;
      end
      for (int k = 0; k < 5; k++)
         r[7*k +: 7] = (blank && k > highest) ? 7'h7F : seg_of(digit[k]);
      return r;
   endfunction

   // Behavioural model: a request starts a 17-cycle countdown ending in the update
   int          m_left;
   int          m_val;
   bit          m_prev;
   bit          m_done;
   logic [34:0] m_b, m_n;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left = 0;
         m_prev = 1'b0;
         m_done = 1'b0;
         m_b    = expect_disp(0, 1'b1);
         m_n    = expect_disp(0, 1'b0);
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_b    = expect_disp(m_val, 1'b1);
               m_n    = expect_disp(m_val, 1'b0);
            end
         end else if (flag && !m_prev) begin
            m_val  = int'(data);
            m_left = 17;
         end
         m_prev = flag;
      end
   end

   task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("blank_disp",   b_all, m_b);
         chk("noblank_disp", n_all, m_n);
         chk("blank_busy",   35'(b_busy), 35'(m_left > 0));
         chk("blank_done",   35'(b_done), 35'(m_done));
         chk("noblank_busy", 35'(n_busy), 35'(m_left > 0));
         chk("noblank_done", 35'(n_done), 35'(m_done));
         chk("busy_done_excl", 35'(b_busy & b_done), 35'(0));
         if (b_done) done_cnt++;
      end
   end

   // One request with a one-cycle FLAG pulse; data is scrambled after capture
   task automatic convert(input logic [15:0] v, output int bcnt);
      bit seen;
      seen = 1'b0;
      bcnt = 0;
      @(negedge clk);
      flag = 1'b1;
      data = v;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         flag = 1'b0;
         data = ~v;
         if (b_busy) bcnt++;
         if (b_done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 35'(0), 35'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      int bc;
      int d0;
      reset = 1'b1;
      flag  = 1'b0;
      data  = '0;
      checking = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hex0", 35'(b_hex0), 35'(7'h40));
      chk("rst_hex4_blank", 35'(b_hex4), 35'(7'h7F));
      chk("rst_hex1_noblank", 35'(n_hex1), 35'(7'h40));
      chk("rst_busy", 35'(b_busy), 35'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_disp", b_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      chk("idle_done", 35'(b_done), 35'(0));

      convert(16'd12345, bc);
      chk("busy_cycles", 35'(bc), 35'(17));
      chk("disp_12345", b_all, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      chk("disp_12345_nb", n_all, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      @(negedge clk);
      chk("done_one_cycle", 35'(b_done), 35'(0));
      chk("done_count_1", 35'(done_cnt), 35'(1));

      convert(16'd0, bc);
      chk("disp_0", b_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      chk("disp_0_nb", n_all, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

      convert(16'd65535, bc);
      chk("disp_65535", b_all, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});

      convert(16'd7, bc);
      chk("disp_7_nb", n_all, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78});
      chk("disp_7", b_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});

      // Second request at edge N+5 is ignored
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      flag = 1'b1;
      data = 16'd4321;
      @(negedge clk);
      flag = 1'b0;
      data = 16'd0;
      repeat (4) @(negedge clk);
      flag = 1'b1;
      data = 16'd999;
      @(negedge clk);
      flag = 1'b0;
      repeat (20) @(negedge clk);
      chk("ignore_disp", b_all, {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79});
      chk("ignore_done_cnt", 35'(done_cnt - d0), 35'(1));

      // FLAG held high for 40 cycles gives a single conversion
      d0 = done_cnt;
      flag = 1'b1;
      data = 16'd808;
      repeat (40) @(negedge clk);
      flag = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_done_cnt", 35'(done_cnt - d0), 35'(1));
      chk("held_disp", b_all, {7'h7F, 7'h7F, 7'h00, 7'h40, 7'h00});

      // Reset at edge N+8 aborts the conversion
      flag = 1'b1;
      data = 16'd54321;
      @(posedge clk);
      #1 flag = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("pre_reset_busy", 35'(b_busy), 35'(1));
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_disp", b_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      chk("abort_busy", 35'(b_busy), 35'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      chk("abort_no_done", 35'(done_cnt), 35'(d0));

      convert(16'd100, bc);
      chk("disp_100", b_all, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
